isdu_ctrl: RTL

ISDU_CTRL -- requirements
Module: isdu_ctrl

---
 rtl/slc3_pkg.sv | 66 ++++++
 rtl/isdu_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - shared SLC-3 control encodings: states, opcodes, strobe indices, mux codes
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_F_MAR,
        S_F_RD,
        S_F_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,
        S_BR_TK,
        S_JMP,
        S_JSR_LINK,
        S_JSR_JMP,
        S_LDR_MAR,
        S_LDR_RD,
        S_LDR_WB,
        S_STR_MAR,
        S_STR_MDR,
        S_STR_WR,
        S_PAUSE_HOLD,
        S_PAUSE_REL
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam int LD_MAR = 0;
    localparam int LD_MDR = 1;
    localparam int LD_IR  = 2;
    localparam int LD_BEN = 3;
    localparam int LD_CC  = 4;
    localparam int LD_REG = 5;
    localparam int LD_PC  = 6;
    localparam int LD_LED = 7;

    localparam int GATE_PC     = 0;
    localparam int GATE_MDR    = 1;
    localparam int GATE_ALU    = 2;
    localparam int GATE_MARMUX = 3;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

endpackage

// File: rtl/isdu_ctrl.sv
// rtl/isdu_ctrl.sv - SLC-3 instruction sequencer / decode unit (Moore control FSM)
module isdu_ctrl
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic [7:0] LD,
    output logic [3:0] GATE,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state, state_nx;
    logic [2:0] wait_cnt;
    logic       wait_done;

    assign wait_done = (wait_cnt == WAIT_LAST);

    // Counter restarts on every state change and saturates so PAUSE_HOLD sees a single first cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= S_HALTED;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wait_cnt <= '0;
            else if (wait_cnt != 3'd7)
                wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_comb begin
        state_nx = state;
        LD       = '0;
        GATE     = '0;
        PCMUX    = PCMUX_INC;
        DRMUX    = 1'b0;
        SR1MUX   = 1'b0;
        SR2MUX   = 1'b0;
        ADDR1MUX = 1'b0;
        ADDR2MUX = ADDR2_ZERO;
        ALUK     = ALUK_ADD;
        Mem_OE   = 1'b0;
        Mem_WE   = 1'b0;

        case (state)
            S_HALTED: if (Run) state_nx = S_F_MAR;
            S_F_MAR: begin
                GATE[GATE_PC] = 1'b1;
                LD[LD_MAR]    = 1'b1;
                LD[LD_PC]     = 1'b1;
                state_nx      = S_F_RD;
            end
            S_F_RD: begin
                Mem_OE = 1'b1;
                if (wait_done) begin
                    LD[LD_MDR] = 1'b1;
                    state_nx   = S_F_IR;
                end
            end
            S_F_IR: begin
                GATE[GATE_MDR] = 1'b1;
                LD[LD_IR]      = 1'b1;
                state_nx       = S_DECODE;
            end
            S_DECODE: begin
                LD[LD_BEN] = 1'b1;
                case (Opcode)
                    OP_ADD:   state_nx = S_ADD;
                    OP_AND:   state_nx = S_AND;
                    OP_NOT:   state_nx = S_NOT;
                    OP_BR:    state_nx = S_BR;
                    OP_JMP:   state_nx = S_JMP;
                    OP_JSR:   state_nx = S_JSR_LINK;
                    OP_LDR:   state_nx = S_LDR_MAR;
                    OP_STR:   state_nx = S_STR_MAR;
                    OP_PAUSE: state_nx = S_PAUSE_HOLD;
                    default:  state_nx = S_F_MAR;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                GATE[GATE_ALU] = 1'b1;
                LD[LD_REG]     = 1'b1;
                LD[LD_CC]      = 1'b1;
                SR1MUX         = 1'b1;
                SR2MUX         = (state != S_NOT) ? IR_5 : 1'b0;
                ALUK           = (state == S_ADD) ? ALUK_ADD :
                                 (state == S_AND) ? ALUK_AND : ALUK_NOT;
                state_nx       = S_F_MAR;
            end
            S_BR: state_nx = BEN ? S_BR_TK : S_F_MAR;
            S_BR_TK: begin
                ADDR2MUX  = ADDR2_OFF9;
                PCMUX     = PCMUX_ADDER;
                LD[LD_PC] = 1'b1;
                state_nx  = S_F_MAR;
            end
            S_JMP: begin
                SR1MUX    = 1'b1;
                ADDR1MUX  = 1'b1;
                PCMUX     = PCMUX_ADDER;
                LD[LD_PC] = 1'b1;
                state_nx  = S_F_MAR;
            end
            S_JSR_LINK: begin
                GATE[GATE_PC] = 1'b1;
                DRMUX         = 1'b1;
                LD[LD_REG]    = 1'b1;
                state_nx      = S_JSR_JMP;
            end
            S_JSR_JMP: begin
                PCMUX     = PCMUX_ADDER;
                LD[LD_PC] = 1'b1;
                if (IR_11) begin
                    ADDR2MUX = ADDR2_OFF11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
                state_nx = S_F_MAR;
            end
            S_LDR_MAR, S_STR_MAR: begin
                SR1MUX            = 1'b1;
                ADDR1MUX          = 1'b1;
                ADDR2MUX          = ADDR2_OFF6;
                GATE[GATE_MARMUX] = 1'b1;
                LD[LD_MAR]        = 1'b1;
                state_nx          = (state == S_LDR_MAR) ? S_LDR_RD : S_STR_MDR;
            end
            S_LDR_RD: begin
                Mem_OE = 1'b1;
                if (wait_done) begin
                    LD[LD_MDR] = 1'b1;
                    state_nx   = S_LDR_WB;
                end
            end
            S_LDR_WB: begin
                GATE[GATE_MDR] = 1'b1;
                LD[LD_REG]     = 1'b1;
                LD[LD_CC]      = 1'b1;
                state_nx       = S_F_MAR;
            end
            S_STR_MDR: begin
                ALUK           = ALUK_PASS;
                GATE[GATE_ALU] = 1'b1;
                LD[LD_MDR]     = 1'b1;
                state_nx       = S_STR_WR;
            end
            S_STR_WR: begin
                Mem_WE = 1'b1;
                if (wait_done) state_nx = S_F_MAR;
            end
            S_PAUSE_HOLD: begin
                LD[LD_LED] = (wait_cnt == 3'd0);
                if (Continue) state_nx = S_PAUSE_REL;
            end
            S_PAUSE_REL: if (!Continue) state_nx = S_F_MAR;
            default: state_nx = S_HALTED;
        endcase
    end

endmodule
